button_conditioner: RTL and testbench

Input-conditioning stage that sits directly upstream of the ALU module on the board. It synchronizes and debounces the three push buttons and the 8-bit switch bus. Each confirmed press becomes a single-cycle pulse on the ALU's b1/b2/b3 inputs, and the operand/opcode byte presented on `entrada` is guaranteed stable for the whole pulse cycle. One clock domain; all mechanical inputs are treated as asynchronous.

---
 rtl/button_conditioner_pkg.sv | 14 +
 rtl/debounce_channel.sv | 93 +++++++++
 rtl/button_conditioner.sv | 51 +++++
 tb/tb_button_conditioner.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the push-button / switch conditioning stage.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } btn_state_e;

  localparam int unsigned DEBOUNCE_BOARD = 500000;
  localparam int unsigned DEBOUNCE_SIM   = 4;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, debounce FSM and counter.
// Emits a registered one-cycle press pulse plus the debounced level.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_BOARD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse,
  output logic level,
  output logic pulse_c
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  btn_state_e       state_q;
  btn_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse   <= 1'b0;
      level   <= 1'b0;
    end else begin
      s1      <= btn_raw;
      s2      <= s1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse   <= pulse_c;
      level   <= level_d;
    end
  end

  // Counter only advances while the input agrees with the pending level,
  // and stops at CNT_MAX because that cycle always leaves the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2) begin
          state_d = ARMING;
          cnt_d   = '0;
        end
      end
      ARMING: begin
        if (!s2) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          pulse_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s2) begin
          state_d = RELEASING;
          cnt_d   = '0;
        end
      end
      RELEASING: begin
        if (s2) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == RELEASING);
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounces N_BTN buttons into single-cycle press pulses and latches the
// synchronized switch bus on every accepted press for the downstream ALU.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_BOARD,
  parameter int unsigned DATA_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BTN-1:0]  btn_raw,
  input  logic [DATA_W-1:0] sw_raw,
  output logic [N_BTN-1:0]  b_pulse,
  output logic [N_BTN-1:0]  b_level,
  output logic [DATA_W-1:0] entrada
);

  logic [N_BTN-1:0]  pulse_c;
  logic [DATA_W-1:0] sw_s1;
  logic [DATA_W-1:0] sw_s2;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_raw[i]),
      .pulse  (b_pulse[i]),
      .level  (b_level[i]),
      .pulse_c(pulse_c[i])
    );
  end

  // Capture lands on the same edge the pulse rises, so entrada is valid with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      entrada <= '0;
    end else begin
      sw_s1 <= sw_raw;
      sw_s2 <= sw_s1;
      if (|pulse_c) begin
        entrada <= sw_s2;
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn_raw;
  logic [7:0] sw_raw;
  logic [2:0] b_pulse;
  logic [2:0] b_level;
  logic [7:0] entrada;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [2:0] btn;
    logic [7:0] sw;
    logic [2:0] ep;
    logic [2:0] el;
    logic [7:0] ee;
  } vec_t;

  vec_t vecs[$];

  button_conditioner #(
    .N_BTN(3),
    .DEBOUNCE_CYCLES(4),
    .DATA_W(8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_raw),
    .sw_raw (sw_raw),
    .b_pulse(b_pulse),
    .b_level(b_level),
    .entrada(entrada)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [2:0] btn, input logic [7:0] sw,
                     input logic [2:0] ep, input logic [2:0] el, input logic [7:0] ee);
    vec_t v;
    v.rst = rst; v.btn = btn; v.sw = sw; v.ep = ep; v.el = el; v.ee = ee;
    vecs.push_back(v);
  endtask

  // Inputs already applied; pulse must stay low for n-1 edges and equal mask on edge n.
  task automatic press_expect(input string name, input logic [2:0] mask, input int n);
    for (int k = 1; k < n; k++) begin
      step(1);
      chk({name, "_early"}, 8'(b_pulse), 8'h00);
    end
    step(1);
    chk({name, "_pulse"}, 8'(b_pulse), 8'(mask));
    chk({name, "_level"}, 8'(b_level & mask), 8'(mask));
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 3'b000;
    sw_raw  = 8'h00;

    // Clean press and release of b1, one row per clock edge.
    add(1, 3'b000, 8'h00, 3'b000, 3'b000, 8'h00);
    add(0, 3'b001, 8'h07, 3'b000, 3'b000, 8'h00);
    for (int i = 0; i < 5; i++) add(0, 3'b001, 8'h07, 3'b000, 3'b000, 8'h00);
    add(0, 3'b001, 8'h07, 3'b001, 3'b001, 8'h07);
    add(0, 3'b001, 8'h07, 3'b000, 3'b001, 8'h07);
    add(0, 3'b000, 8'h07, 3'b000, 3'b001, 8'h07);
    for (int i = 0; i < 5; i++) add(0, 3'b000, 8'h07, 3'b000, 3'b001, 8'h07);
    add(0, 3'b000, 8'h07, 3'b000, 3'b000, 8'h07);
    add(0, 3'b000, 8'h07, 3'b000, 3'b000, 8'h07);

    for (int i = 0; i < vecs.size(); i++) begin
      reset   = vecs[i].rst;
      btn_raw = vecs[i].btn;
      sw_raw  = vecs[i].sw;
      step(1);
      chk($sformatf("vec%0d_pulse", i), 8'(b_pulse), 8'(vecs[i].ep));
      chk($sformatf("vec%0d_level", i), 8'(b_level), 8'(vecs[i].el));
      chk($sformatf("vec%0d_entrada", i), entrada, vecs[i].ee);
    end

    // Bounce on b2: toggling never completes the count; final hold pulses once.
    for (int k = 0; k < 4; k++) begin
      btn_raw = (k % 2 == 0) ? 3'b010 : 3'b000;
      step(1);
      chk("bounce_quiet", 8'(b_pulse), 8'h00);
    end
    btn_raw = 3'b010;
    press_expect("bounce", 3'b010, 7);
    step(1);
    chk("bounce_single", 8'(b_pulse), 8'h00);
    btn_raw = 3'b000;
    step(10);
    chk("bounce_released", 8'(b_level), 8'h00);

    // Data stability: entrada holds the press-time byte while switches move.
    sw_raw = 8'h03;
    step(3);
    btn_raw = 3'b001;
    press_expect("data_b1", 3'b001, 7);
    chk("data_b1_entrada", entrada, 8'h03);
    sw_raw = 8'h22;
    step(5);
    chk("data_hold_entrada", entrada, 8'h03);
    btn_raw = 3'b000;
    step(7);
    chk("data_b1_released", 8'(b_level), 8'h00);
    chk("data_after_release_entrada", entrada, 8'h03);
    btn_raw = 3'b100;
    press_expect("data_b3", 3'b100, 7);
    chk("data_b3_entrada", entrada, 8'h22);

    // Release glitch on b3: two low cycles must not drop the level or re-pulse.
    step(2);
    btn_raw = 3'b000;
    step(2);
    btn_raw = 3'b100;
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("glitch_level", 8'(b_level), 8'h04);
      chk("glitch_pulse", 8'(b_pulse), 8'h00);
    end
    btn_raw = 3'b000;
    step(10);
    chk("glitch_released", 8'(b_level), 8'h00);

    // Simultaneous b2+b3 press: one shared pulse cycle and one capture.
    sw_raw = 8'h5a;
    step(3);
    btn_raw = 3'b110;
    press_expect("simul", 3'b110, 7);
    chk("simul_entrada", entrada, 8'h5a);
    sw_raw = 8'hc3;
    step(1);
    chk("simul_single", 8'(b_pulse), 8'h00);
    chk("simul_entrada_hold", entrada, 8'h5a);
    btn_raw = 3'b000;
    step(10);
    chk("simul_released", 8'(b_level), 8'h00);

    // Reset during ARMING clears everything; the still-held button re-presses.
    btn_raw = 3'b001;
    step(4);
    chk("rst_arming_pulse", 8'(b_pulse), 8'h00);
    reset = 1'b1;
    step(1);
    chk("rst_pulse", 8'(b_pulse), 8'h00);
    chk("rst_level", 8'(b_level), 8'h00);
    chk("rst_entrada", entrada, 8'h00);
    reset = 1'b0;
    press_expect("post_rst", 3'b001, 7);
    chk("post_rst_entrada", entrada, 8'hc3);
    step(1);
    chk("post_rst_single", 8'(b_pulse), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
